// File: rtl/l2_mac_sched.sv
// Round-robin scheduler sharing one sum-of-squares MAC datapath between two requesters.
// One vector in flight at a time; the final accumulator is returned with owner ID and overflow.
module l2_mac_sched #(
  parameter int unsigned VEC_LEN = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  output logic              req1_ready,
  output logic [DATA_W-1:0] dp_a,
  output logic              dp_valid_in,
  output logic              dp_clear,
  input  logic [ACC_W-1:0]  dp_f,
  input  logic              dp_valid_out,
  input  logic              dp_overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [ACC_W-1:0]  res_f,
  output logic              res_overflow
);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(VEC_LEN - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(VEC_LEN);

  state_e state_q, state_d;

  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] dp_a_q, dp_a_d;
  logic              dp_valid_in_q, dp_valid_in_d;
  logic              dp_clear_q, dp_clear_d;
  logic              res_valid_q, res_valid_d;
  logic              res_id_q, res_id_d;
  logic [ACC_W-1:0]  res_f_q, res_f_d;
  logic              res_ovf_q, res_ovf_d;

  logic              any_valid;
  logic              pick;
  logic              g_valid;
  logic [DATA_W-1:0] g_a;
  logic              stream_ready;
  logic              accept;
  logic              last_in;
  logic              track;
  logic              last_out;
  logic              out_done;

  assign any_valid = req0_valid | req1_valid;
  // Prefer the requester that was not served last; fall back to whichever is valid.
  assign pick      = last_grant_q ? ~req0_valid : req1_valid;

  assign g_valid      = grant_q ? req1_valid : req0_valid;
  assign g_a          = grant_q ? req1_a : req0_a;
  assign stream_ready = (state_q == StStream) && (in_cnt_q < FullCnt);
  assign req0_ready   = stream_ready && !grant_q;
  assign req1_ready   = stream_ready && grant_q;

  assign accept   = stream_ready && g_valid;
  assign last_in  = accept && (in_cnt_q == LastCnt);
  assign track    = (state_q == StStream) || (state_q == StDrain);
  assign last_out = track && dp_valid_out && (out_cnt_q == LastCnt);
  assign out_done = last_out || (out_cnt_q == FullCnt);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_valid) state_d = StStream;
      // A result already captured during streaming skips the drain phase.
      StStream: if (last_in) state_d = out_done ? StDone : StDrain;
      StDrain:  if (out_done) state_d = StDone;
      StDone:   if (res_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    ovf_d         = ovf_q;
    dp_a_d        = dp_a_q;
    dp_valid_in_d = 1'b0;
    dp_clear_d    = 1'b0;
    res_valid_d   = res_valid_q;
    res_id_d      = res_id_q;
    res_f_d       = res_f_q;
    res_ovf_d     = res_ovf_q;

    if ((state_q == StIdle) && any_valid) begin
      grant_d    = pick;
      dp_clear_d = 1'b1;
      in_cnt_d   = '0;
      out_cnt_d  = '0;
      ovf_d      = 1'b0;
    end

    if (accept) begin
      dp_a_d        = g_a;
      dp_valid_in_d = 1'b1;
      in_cnt_d      = in_cnt_q + 1'b1;
    end

    // Strobes beyond VEC_LEN are protocol errors; the counter holds instead of wrapping.
    if (track && dp_valid_out && (out_cnt_q != FullCnt)) begin
      out_cnt_d = out_cnt_q + 1'b1;
      ovf_d     = ovf_q | dp_overflow;
    end

    if (last_out) begin
      res_f_d   = dp_f;
      res_ovf_d = ovf_q | dp_overflow;
      res_id_d  = grant_q;
    end

    if ((state_q != StDone) && (state_d == StDone)) begin
      res_valid_d = 1'b1;
    end

    if ((state_q == StDone) && res_ready) begin
      res_valid_d  = 1'b0;
      last_grant_d = grant_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      ovf_q         <= 1'b0;
      dp_a_q        <= '0;
      dp_valid_in_q <= 1'b0;
      dp_clear_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_id_q      <= 1'b0;
      res_f_q       <= '0;
      res_ovf_q     <= 1'b0;
    end else begin
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      ovf_q         <= ovf_d;
      dp_a_q        <= dp_a_d;
      dp_valid_in_q <= dp_valid_in_d;
      dp_clear_q    <= dp_clear_d;
      res_valid_q   <= res_valid_d;
      res_id_q      <= res_id_d;
      res_f_q       <= res_f_d;
      res_ovf_q     <= res_ovf_d;
    end
  end

  assign dp_a         = dp_a_q;
  assign dp_valid_in  = dp_valid_in_q;
  assign dp_clear     = dp_clear_q;
  assign res_valid    = res_valid_q;
  assign res_id       = res_id_q;
  assign res_f        = res_f_q;
  assign res_overflow = res_ovf_q;

endmodule

// File: tb/tb_l2_mac_sched.sv
// Bench for l2_mac_sched: two-stage sum-of-squares datapath model plus directed vectors.
module tb_l2_mac_sched;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req1_a;
  logic        req0_ready, req1_ready;
  logic [7:0]  dp_a;
  logic        dp_valid_in, dp_clear;
  logic [19:0] dp_f;
  logic        dp_valid_out, dp_overflow;
  logic        res_valid, res_ready, res_id, res_overflow;
  logic [19:0] res_f;

  int n_checks = 0;
  int n_errors = 0;

  l2_mac_sched #(
    .VEC_LEN(4),
    .DATA_W (8),
    .ACC_W  (20),
    .CNT_W  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_ready  (req1_ready),
    .dp_a        (dp_a),
    .dp_valid_in (dp_valid_in),
    .dp_clear    (dp_clear),
    .dp_f        (dp_f),
    .dp_valid_out(dp_valid_out),
    .dp_overflow (dp_overflow),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_f       (res_f),
    .res_overflow(res_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: latency 2, accumulates squares, optional overflow on the 2nd output.
  logic        v1, v2, ovf_en;
  logic [7:0]  a1;
  logic [19:0] acc;
  int          ocnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; v2 <= 1'b0; a1 <= '0; acc <= '0; ocnt <= 0;
    end else begin
      v1 <= dp_valid_in;
      a1 <= dp_a;
      v2 <= v1;
      if (dp_clear) begin
        acc  <= '0;
        ocnt <= 0;
      end else begin
        if (v1) acc <= acc + 20'(a1) * 20'(a1);
        if (v2) ocnt <= ocnt + 1;
      end
    end
  end

  assign dp_valid_out = v2;
  assign dp_f         = acc;
  assign dp_overflow  = v2 && ovf_en && (ocnt == 1);

  // Monitor
  int          clear_cnt = 0, dvi_cnt = 0, dvi_run = 0, dvi_max = 0;
  int          rdy0_cnt = 0, rdy1_cnt = 0, resv_cnt = 0;
  logic        got_id[$];
  logic [19:0] got_f[$];
  logic        got_ovf[$];

  always @(negedge clk) begin
    if (dp_clear) clear_cnt++;
    if (dp_valid_in) begin
      dvi_cnt++;
      dvi_run++;
      if (dvi_run > dvi_max) dvi_max = dvi_run;
    end else begin
      dvi_run = 0;
    end
    if (req0_ready) rdy0_cnt++;
    if (req1_ready) rdy1_cnt++;
    if (res_valid) resv_cnt++;
    if (res_valid && res_ready) begin
      got_id.push_back(res_id);
      got_f.push_back(res_f);
      got_ovf.push_back(res_overflow);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, {req0_ready, req1_ready, dp_valid_in, dp_clear, res_valid, res_id, res_overflow,
                dp_a, res_f}, 64'd0);
  endtask

  task automatic drive(input bit id, input logic v, input logic [7:0] a);
    if (id) begin
      req1_valid = v; req1_a = a;
    end else begin
      req0_valid = v; req0_a = a;
    end
  endtask

  // Element i of the vector is vals[8*i +: 8]; gap = idle cycles between beats.
  task automatic send_vec(input bit id, input logic [31:0] vals, input int gap, input bit keep);
    for (int i = 0; i < 4; i++) begin
      int k;
      @(negedge clk);
      drive(id, 1'b1, vals[8*i +: 8]);
      k = 0;
      while (!(id ? req1_ready : req0_ready) && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("beat_ready", 64'(id ? req1_ready : req0_ready), 64'd1);
      if (k >= 200) return;
      @(posedge clk);
      if (i == 3) begin
        if (!keep) begin
          @(negedge clk);
          drive(id, 1'b0, 8'd0);
        end
      end else if (gap > 0) begin
        @(negedge clk);
        drive(id, 1'b0, 8'd0);
        repeat (gap - 1) @(negedge clk);
      end
    end
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (got_f.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("result_count", 64'(got_f.size()), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 100000", $time);
    $fatal(1);
  end

  initial begin
    int k, c0, c1, cc;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_a = '0; req1_a = '0;
    res_ready = 1'b0; ovf_en = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_outputs");
    reset = 1'b1;
    @(negedge clk);

    // Single vector 1,2,3,4 from req0
    res_ready = 1'b1;
    send_vec(1'b0, 32'h04030201, 0, 1'b0);
    wait_results(1);
    repeat (3) @(negedge clk);
    check("t1_clear_pulses", 64'(clear_cnt), 64'd1);
    check("t1_dvi_cycles", 64'(dvi_cnt), 64'd4);
    check("t1_dvi_consecutive", 64'(dvi_max), 64'd4);
    check("t1_res_valid_cycles", 64'(resv_cnt), 64'd1);
    check("t1_rdy0_cycles", 64'(rdy0_cnt), 64'd4);
    check("t1_rdy1_cycles", 64'(rdy1_cnt), 64'd0);
    check("t1_f", 64'(got_f[0]), 64'd30);
    check("t1_id", 64'(got_id[0]), 64'd0);
    check("t1_ovf", 64'(got_ovf[0]), 64'd0);

    // Round robin, both requesters continuously valid
    c0 = rdy0_cnt; c1 = rdy1_cnt; cc = clear_cnt;
    fork
      begin
        send_vec(1'b0, 32'h01010101, 0, 1'b1);
        send_vec(1'b0, 32'h01010101, 0, 1'b1);
      end
      begin
        @(negedge clk);
        send_vec(1'b1, 32'h02020202, 0, 1'b1);
        send_vec(1'b1, 32'h02020202, 0, 1'b1);
      end
    join
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    wait_results(5);
    check("t2_id_1", 64'(got_id[1]), 64'd0);
    check("t2_f_1", 64'(got_f[1]), 64'd4);
    check("t2_id_2", 64'(got_id[2]), 64'd1);
    check("t2_f_2", 64'(got_f[2]), 64'd16);
    check("t2_id_3", 64'(got_id[3]), 64'd0);
    check("t2_f_3", 64'(got_f[3]), 64'd4);
    check("t2_id_4", 64'(got_id[4]), 64'd1);
    check("t2_f_4", 64'(got_f[4]), 64'd16);
    check("t2_rdy0_cycles", 64'(rdy0_cnt - c0), 64'd8);
    check("t2_rdy1_cycles", 64'(rdy1_cnt - c1), 64'd8);
    check("t2_clear_pulses", 64'(clear_cnt - cc), 64'd4);

    // Gaps on req1 and result backpressure
    res_ready = 1'b0;
    send_vec(1'b1, 32'hFF070005, 3, 1'b0);
    k = 0;
    while (!res_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t3_res_valid", 64'(res_valid), 64'd1);
    ovf_en = 1'b1;
    fork
      send_vec(1'b0, 32'h04030201, 0, 1'b0);
    join_none
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 64'(res_valid), 64'd1);
      check("t3_hold_f", 64'(res_f), 64'd65099);
      check("t3_hold_id", 64'(res_id), 64'd1);
      check("t3_hold_readys", 64'({req0_ready, req1_ready}), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    check("t3_accept_valid", 64'(res_valid), 64'd1);
    @(negedge clk);
    check("t3_after_accept_valid", 64'(res_valid), 64'd0);
    check("t3_no_early_grant", 64'({dp_clear, req0_ready}), 64'd0);
    @(negedge clk);
    check("t3_grant_next", 64'({dp_clear, req0_ready}), 64'd3);

    // Overflow on the 2nd datapath output only, then a clean vector
    wait_results(7);
    check("t3_f", 64'(got_f[5]), 64'd65099);
    check("t3_id", 64'(got_id[5]), 64'd1);
    check("t3_ovf", 64'(got_ovf[5]), 64'd0);
    check("t4_f", 64'(got_f[6]), 64'd30);
    check("t4_id", 64'(got_id[6]), 64'd0);
    check("t4_ovf", 64'(got_ovf[6]), 64'd1);
    ovf_en = 1'b0;
    send_vec(1'b0, 32'h04030201, 0, 1'b0);
    wait_results(8);
    check("t4b_f", 64'(got_f[7]), 64'd30);
    check("t4b_ovf", 64'(got_ovf[7]), 64'd0);

    // Reset after two accepted beats
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd9);
    k = 0;
    while (!req0_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t5_ready", 64'(req0_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check_idle("t5_async_reset");
    drive(1'b0, 1'b0, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cc = resv_cnt;
    repeat (10) @(negedge clk);
    check("t5_no_res_valid", 64'(resv_cnt - cc), 64'd0);
    check("t5_no_result", 64'(got_f.size()), 64'd8);
    send_vec(1'b0, 32'h02020202, 0, 1'b0);
    wait_results(9);
    check("t5_f", 64'(got_f[8]), 64'd16);
    check("t5_id", 64'(got_id[8]), 64'd0);
    check("t5_ovf", 64'(got_ovf[8]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
